// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Module : rv32_pkg
// Brief  : Shared types and constants for the RV32IM fetch front end.
// Rev    : 1.0
// ============================================================================
package rv32_pkg;

  localparam int          DEF_WIDTH = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // ADDI x0,x0,0

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/if_id_register.sv
`default_nettype none
// ============================================================================
// Module : if_id_register
// Brief  : IF/ID pipeline register with load, hold and bubble controls.
// Rev    : 1.0
// ============================================================================
module if_id_register
  import rv32_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_bubble,
  input  logic [WIDTH-1:0] i_instr,
  input  logic [WIDTH-1:0] i_pc,
  output logic [WIDTH-1:0] o_instruction,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_pc_plus4,
  output logic             o_valid
);

  // A bubble keeps the PC fields so decode still sees the last PC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_instruction <= WIDTH'(NOP_INSTR);
      o_pc          <= '0;
      o_pc_plus4    <= '0;
      o_valid       <= 1'b0;
    end else if (i_load) begin
      o_instruction <= i_instr;
      o_pc          <= i_pc;
      o_pc_plus4    <= i_pc + WIDTH'(4);
      o_valid       <= 1'b1;
    end else if (i_bubble) begin
      o_instruction <= WIDTH'(NOP_INSTR);
      o_valid       <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : instruction_fetch_unit
// Brief  : IF stage with PC, busywait memory handshake, stall hold buffer,
//          EX-stage redirect and IF/ID register.
// Rev    : 1.0
// ============================================================================
module instruction_fetch_unit
  import rv32_pkg::*;
#(
  parameter int               WIDTH    = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  output logic [WIDTH-1:0] IMEM_ADDR,
  output logic             IMEM_READ,
  input  logic [WIDTH-1:0] IMEM_READDATA,
  input  logic             IMEM_BUSYWAIT,
  input  logic             STALL,
  input  logic             BRANCH_TAKEN,
  input  logic [WIDTH-1:0] BRANCH_TARGET,
  output logic [WIDTH-1:0] INSTRUCTION,
  output logic [WIDTH-1:0] PC_OUT,
  output logic [WIDTH-1:0] PC_PLUS4_OUT,
  output logic             INSTR_VALID
);

  fetch_state_t     r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_redir;
  logic [WIDTH-1:0] r_buf_instr;
  logic [WIDTH-1:0] r_buf_pc;

  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_pc_next;
  logic             w_done;
  logic             w_load;
  logic             w_bubble;
  logic             w_from_buf;
  logic [WIDTH-1:0] w_load_instr;
  logic [WIDTH-1:0] w_load_pc;

  assign w_target  = {BRANCH_TARGET[WIDTH-1:2], 2'b00};
  assign w_pc_next = r_pc + WIDTH'(4);
  assign IMEM_READ = RESET && (r_state != HOLD);
  assign IMEM_ADDR = r_pc;
  assign w_done    = IMEM_READ && !IMEM_BUSYWAIT;

  always_comb begin
    w_load     = 1'b0;
    w_bubble   = 1'b0;
    w_from_buf = 1'b0;
    case (r_state)
      FETCH: begin
        if (BRANCH_TAKEN) begin
          w_bubble = 1'b1;
        end else if (!STALL) begin
          w_load   = w_done;
          w_bubble = !w_done;
        end
      end
      HOLD: begin
        if (BRANCH_TAKEN) begin
          w_bubble = 1'b1;
        end else if (!STALL) begin
          w_load     = 1'b1;
          w_from_buf = 1'b1;
        end
      end
      default: w_bubble = 1'b1;
    endcase
  end

  assign w_load_instr = w_from_buf ? r_buf_instr : IMEM_READDATA;
  assign w_load_pc    = w_from_buf ? r_buf_pc    : r_pc;

  // In DISCARD the old request stays on the bus until memory completes it.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_redir     <= '0;
      r_buf_instr <= '0;
      r_buf_pc    <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          if (BRANCH_TAKEN) begin
            if (w_done) begin
              r_pc <= w_target;
            end else begin
              r_redir <= w_target;
              r_state <= DISCARD;
            end
          end else if (w_done) begin
            r_pc <= w_pc_next;
            if (STALL) begin
              r_buf_instr <= IMEM_READDATA;
              r_buf_pc    <= r_pc;
              r_state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (BRANCH_TAKEN) begin
            r_pc    <= w_target;
            r_state <= FETCH;
          end else if (!STALL) begin
            r_state <= FETCH;
          end
        end
        DISCARD: begin
          if (w_done) begin
            r_pc    <= BRANCH_TAKEN ? w_target : r_redir;
            r_state <= FETCH;
          end else if (BRANCH_TAKEN) begin
            r_redir <= w_target;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  if_id_register #(
    .WIDTH(WIDTH)
  ) u_if_id (
    .clk          (CLK),
    .rst_n        (RESET),
    .i_load       (w_load),
    .i_bubble     (w_bubble),
    .i_instr      (w_load_instr),
    .i_pc         (w_load_pc),
    .o_instruction(INSTRUCTION),
    .o_pc         (PC_OUT),
    .o_pc_plus4   (PC_PLUS4_OUT),
    .o_valid      (INSTR_VALID)
  );

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_instruction_fetch_unit
// Brief  : Self-checking bench for instruction_fetch_unit.
// Rev    : 1.0
// ============================================================================
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] OFS = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_READ;
  logic [31:0] IMEM_READDATA;
  logic        IMEM_BUSYWAIT = 1'b0;
  logic        STALL = 1'b0;
  logic        BRANCH_TAKEN = 1'b0;
  logic [31:0] BRANCH_TARGET = '0;
  logic [31:0] INSTRUCTION;
  logic [31:0] PC_OUT;
  logic [31:0] PC_PLUS4_OUT;
  logic        INSTR_VALID;

  logic [96:0] ifid;
  logic [32:0] req;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Memory returns address + 0x100 for every word.
  assign IMEM_READDATA = IMEM_ADDR + OFS;
  assign ifid = {INSTR_VALID, INSTRUCTION, PC_OUT, PC_PLUS4_OUT};
  assign req  = {IMEM_READ, IMEM_ADDR};

  instruction_fetch_unit #(
    .WIDTH(32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .CLK          (clk),
    .RESET        (RESET),
    .IMEM_ADDR    (IMEM_ADDR),
    .IMEM_READ    (IMEM_READ),
    .IMEM_READDATA(IMEM_READDATA),
    .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
    .STALL        (STALL),
    .BRANCH_TAKEN (BRANCH_TAKEN),
    .BRANCH_TARGET(BRANCH_TARGET),
    .INSTRUCTION  (INSTRUCTION),
    .PC_OUT       (PC_OUT),
    .PC_PLUS4_OUT (PC_PLUS4_OUT),
    .INSTR_VALID  (INSTR_VALID)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b0; STALL = 1'b0; BRANCH_TAKEN = 1'b0; IMEM_BUSYWAIT = 1'b0;
    tick(); tick();
    n_checks++; if (ifid !== {1'b0, NOP, 32'h0, 32'h0}) begin n_fail++; $display("FAIL reset_ifid: got %h want %h", ifid, {1'b0, NOP, 32'h0, 32'h0}); end
    n_checks++; if (IMEM_READ !== 1'b0) begin n_fail++; $display("FAIL reset_read: got %b want 0", IMEM_READ); end
  endtask

  task automatic test_zero_wait();
    logic [96:0] exp;
    RESET = 1'b1; #1;
    n_checks++; if (req !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL zw_first_req: got %h want %h", req, {1'b1, 32'h0}); end
    for (int i = 0; i < 3; i++) begin
      tick();
      exp = {1'b1, OFS + 32'(4*i), 32'(4*i), 32'(4*i + 4)};
      n_checks++; if (ifid !== exp) begin n_fail++; $display("FAIL zw_ifid%0d: got %h want %h", i, ifid, exp); end
    end
  endtask

  task automatic test_busywait();
    logic [31:0] pc;
    logic [96:0] exp;
    for (int a = 0; a < 2; a++) begin
      pc = 32'(12 + 4*a);
      IMEM_BUSYWAIT = 1'b1;
      for (int k = 0; k < 3; k++) begin
        tick();
        n_checks++; if (ifid[96:32] !== {1'b0, NOP, pc - 32'd4}) begin n_fail++; $display("FAIL bw_bubble: got %h want %h", ifid[96:32], {1'b0, NOP, pc - 32'd4}); end
        n_checks++; if (req !== {1'b1, pc}) begin n_fail++; $display("FAIL bw_addr_stable: got %h want %h", req, {1'b1, pc}); end
      end
      IMEM_BUSYWAIT = 1'b0;
      tick();
      exp = {1'b1, pc + OFS, pc, pc + 32'd4};
      n_checks++; if (ifid !== exp) begin n_fail++; $display("FAIL bw_valid: got %h want %h", ifid, exp); end
    end
  endtask

  task automatic test_stall();
    RESET = 1'b0; tick();
    RESET = 1'b1; tick(); tick();
    STALL = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++; if (ifid !== {1'b1, 32'h104, 32'h4, 32'h8}) begin n_fail++; $display("FAIL stall_hold: got %h want %h", ifid, {1'b1, 32'h104, 32'h4, 32'h8}); end
      n_checks++; if (IMEM_READ !== 1'b0) begin n_fail++; $display("FAIL stall_read: got %b want 0", IMEM_READ); end
    end
    STALL = 1'b0;
    tick();
    n_checks++; if (ifid !== {1'b1, 32'h108, 32'h8, 32'hC}) begin n_fail++; $display("FAIL stall_release: got %h want %h", ifid, {1'b1, 32'h108, 32'h8, 32'hC}); end
    tick();
    n_checks++; if (ifid !== {1'b1, 32'h10C, 32'hC, 32'h10}) begin n_fail++; $display("FAIL stall_next: got %h want %h", ifid, {1'b1, 32'h10C, 32'hC, 32'h10}); end
  endtask

  task automatic test_branch_discard();
    IMEM_BUSYWAIT = 1'b1; BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h40;
    tick();
    BRANCH_TAKEN = 1'b0; BRANCH_TARGET = 32'h0;
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (ifid[96:64] !== {1'b0, NOP}) begin n_fail++; $display("FAIL br_bubble: got %h want %h", ifid[96:64], {1'b0, NOP}); end
      n_checks++; if (req !== {1'b1, 32'h10}) begin n_fail++; $display("FAIL br_addr_hold: got %h want %h", req, {1'b1, 32'h10}); end
      if (k == 0) tick();
    end
    IMEM_BUSYWAIT = 1'b0;
    tick();
    n_checks++; if (ifid[96:64] !== {1'b0, NOP}) begin n_fail++; $display("FAIL br_drop: got %h want %h", ifid[96:64], {1'b0, NOP}); end
    n_checks++; if (req !== {1'b1, 32'h40}) begin n_fail++; $display("FAIL br_redirect: got %h want %h", req, {1'b1, 32'h40}); end
    tick();
    n_checks++; if (ifid !== {1'b1, 32'h140, 32'h40, 32'h44}) begin n_fail++; $display("FAIL br_first: got %h want %h", ifid, {1'b1, 32'h140, 32'h40, 32'h44}); end
  endtask

  task automatic test_hold_branch();
    STALL = 1'b1;
    tick();
    n_checks++; if (IMEM_READ !== 1'b0) begin n_fail++; $display("FAIL hb_hold: got %b want 0", IMEM_READ); end
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h23;
    tick();
    BRANCH_TAKEN = 1'b0; STALL = 1'b0;
    n_checks++; if (ifid !== {1'b0, NOP, 32'h40, 32'h44}) begin n_fail++; $display("FAIL hb_flush: got %h want %h", ifid, {1'b0, NOP, 32'h40, 32'h44}); end
    n_checks++; if (req !== {1'b1, 32'h20}) begin n_fail++; $display("FAIL hb_target: got %h want %h", req, {1'b1, 32'h20}); end
    tick();
    n_checks++; if (ifid !== {1'b1, 32'h120, 32'h20, 32'h24}) begin n_fail++; $display("FAIL hb_first: got %h want %h", ifid, {1'b1, 32'h120, 32'h20, 32'h24}); end
  endtask

  task automatic test_wrap();
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'hFFFF_FFFC;
    tick();
    BRANCH_TAKEN = 1'b0;
    n_checks++; if (req !== {1'b1, 32'hFFFF_FFFC}) begin n_fail++; $display("FAIL wrap_req: got %h want %h", req, {1'b1, 32'hFFFF_FFFC}); end
    tick();
    n_checks++; if (ifid !== {1'b1, 32'hFC, 32'hFFFF_FFFC, 32'h0}) begin n_fail++; $display("FAIL wrap_ifid: got %h want %h", ifid, {1'b1, 32'hFC, 32'hFFFF_FFFC, 32'h0}); end
    n_checks++; if (req !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL wrap_next: got %h want %h", req, {1'b1, 32'h0}); end
    tick();
    n_checks++; if (ifid !== {1'b1, 32'h100, 32'h0, 32'h4}) begin n_fail++; $display("FAIL wrap_after: got %h want %h", ifid, {1'b1, 32'h100, 32'h0, 32'h4}); end
  endtask

  task automatic test_reset_mid_wait();
    IMEM_BUSYWAIT = 1'b1;
    tick();
    RESET = 1'b0; #1;
    n_checks++; if (IMEM_READ !== 1'b0) begin n_fail++; $display("FAIL rst_read_comb: got %b want 0", IMEM_READ); end
    tick();
    n_checks++; if (ifid !== {1'b0, NOP, 32'h0, 32'h0}) begin n_fail++; $display("FAIL rst_mid_ifid: got %h want %h", ifid, {1'b0, NOP, 32'h0, 32'h0}); end
    n_checks++; if (IMEM_READ !== 1'b0) begin n_fail++; $display("FAIL rst_mid_read: got %b want 0", IMEM_READ); end
    RESET = 1'b1; IMEM_BUSYWAIT = 1'b0; #1;
    n_checks++; if (req !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL rst_restart: got %h want %h", req, {1'b1, 32'h0}); end
    tick();
    n_checks++; if (ifid !== {1'b1, 32'h100, 32'h0, 32'h4}) begin n_fail++; $display("FAIL rst_first: got %h want %h", ifid, {1'b1, 32'h100, 32'h0, 32'h4}); end
  endtask

  // Program-order model: each delivered instruction must be the next one in
  // sequence, a redirect restarts the sequence at the target, a stall freezes
  // IF/ID, and anything else is a bubble.
  task automatic test_random();
    logic [31:0] exp_next;
    logic [96:0] prev, exp;
    logic [32:0] p_req;
    logic        p_busy, p_stall, p_bt;
    logic [31:0] p_tgt;
    int          n_valid;
    RESET = 1'b0; STALL = 1'b0; BRANCH_TAKEN = 1'b0; IMEM_BUSYWAIT = 1'b0;
    tick();
    RESET = 1'b1;
    exp_next = 32'h0;
    prev     = {1'b0, NOP, 32'h0, 32'h0};
    n_valid  = 0;
    for (int c = 0; c < 3000; c++) begin
      IMEM_BUSYWAIT = ($urandom_range(0, 2) == 0);
      STALL         = ($urandom_range(0, 3) == 0);
      BRANCH_TAKEN  = ($urandom_range(0, 15) == 0);
      BRANCH_TARGET = $urandom;
      #1;
      p_req = req; p_busy = IMEM_BUSYWAIT; p_stall = STALL;
      p_bt = BRANCH_TAKEN; p_tgt = BRANCH_TARGET;
      tick();
      if (p_req[32] && p_busy) begin
        n_checks++; if (req !== p_req) begin n_fail++; $display("FAIL rnd_addr_stable c=%0d: got %h want %h", c, req, p_req); end
      end
      if (p_bt) begin
        exp = {1'b0, NOP, prev[63:0]};
        exp_next = {p_tgt[31:2], 2'b00};
      end else if (p_stall) begin
        exp = prev;
      end else if (INSTR_VALID) begin
        exp = {1'b1, exp_next + OFS, exp_next, exp_next + 32'd4};
        exp_next = exp_next + 32'd4;
        n_valid++;
      end else begin
        exp = {1'b0, NOP, prev[63:0]};
      end
      n_checks++; if (ifid !== exp) begin n_fail++; $display("FAIL rnd_ifid c=%0d: got %h want %h", c, ifid, exp); end
      prev = ifid;
    end
    BRANCH_TAKEN = 1'b0; STALL = 1'b0; IMEM_BUSYWAIT = 1'b0;
    n_checks++; if (n_valid < 200) begin n_fail++; $display("FAIL rnd_progress: got %0d valid want >= 200", n_valid); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_busywait();
    test_stall();
    test_branch_discard();
    test_hold_branch();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
IF stage plus IF/ID pipeline register of the RV32IM pipeline; its INSTRUCTION output drives the control_unit INSTRUCTION input directly.
Owns the PC and handshakes with instruction memory through a busywait protocol.
Absorbs hazard-unit stalls with a one-entry hold buffer and redirects on taken branches/jumps resolved in EX.
Inserts NOP bubbles (ADDI x0,x0,0 = 32'h00000013) whenever no valid instruction is available.

Parameters:
WIDTH, 32, datapath/address width
RESET_PC, 32'h00000000, PC value loaded on reset

Ports:
CLK  input  1  pipeline clock, all state updates on rising edge
RESET  input  1  synchronous, active-low reset
IMEM_ADDR  output  WIDTH  instruction memory word address (byte address, bits [1:0] always 00)
IMEM_READ  output  1  read request
IMEM_READDATA  input  WIDTH  fetched word, valid in a cycle with IMEM_READ=1 and IMEM_BUSYWAIT=0
IMEM_BUSYWAIT  input  1  memory not ready; request must be held unchanged while high
STALL  input  1  hazard unit: hold IF/ID contents
BRANCH_TAKEN  input  1  EX-stage redirect (taken branch, JAL, JALR)
BRANCH_TARGET  input  WIDTH  redirect address; bits [1:0] forced to 00 internally
INSTRUCTION  output  WIDTH  IF/ID instruction to control_unit/decode
PC_OUT  output  WIDTH  IF/ID PC of INSTRUCTION
PC_PLUS4_OUT  output  WIDTH  IF/ID PC_OUT+4 (link value for JAL/JALR)
INSTR_VALID  output  1  IF/ID holds a real instruction (0 = bubble)

Behaviour:
- Reset (RESET=0 at edge):
  - PC<=RESET_PC; state<=FETCH; hold buffer empty
  - INSTRUCTION<=32'h00000013; PC_OUT<=0; PC_PLUS4_OUT<=0; INSTR_VALID<=0
  - IMEM_READ is 0 combinationally while RESET=0; the first request is issued in the cycle after reset release
  - Reset mid-transaction abandons the request; no data is captured.
- Handshake: a transfer completes ("done") in a cycle with IMEM_READ=1 and IMEM_BUSYWAIT=0. IMEM_ADDR is stable while BUSYWAIT=1.
- PC increment: PC+4 modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
- State FETCH (IMEM_READ=1, IMEM_ADDR=PC):
  - BRANCH_TAKEN and BUSYWAIT=1: save target in REDIR; ->DISCARD; IF/ID<=bubble.
  - BRANCH_TAKEN and done: drop data; PC<=target; stay FETCH; IF/ID<=bubble.
  - done, !STALL: IF/ID<={data, PC, PC+4, valid=1}; PC<=PC+4. Throughput 1 instruction/cycle with zero-wait memory.
  - done, STALL: buffer<={data, PC}; PC<=PC+4; ->HOLD; IF/ID unchanged.
  - not done: IF/ID<=bubble if !STALL, else unchanged.
- State HOLD (IMEM_READ=0):
  - BRANCH_TAKEN: clear buffer; PC<=target; IF/ID<=bubble; ->FETCH.
  - !STALL: IF/ID<=buffer (valid=1); ->FETCH.
  - else: stay.
- State DISCARD (IMEM_READ=1, IMEM_ADDR=old PC):
  - A further BRANCH_TAKEN overwrites REDIR.
  - On done: drop data; PC<=REDIR (or the new target if BRANCH_TAKEN is asserted that same cycle); ->FETCH.
  - IF/ID<=bubble every cycle.
- Priority: RESET > BRANCH_TAKEN > STALL. A flush always wins over a stall.
- Bubble: INSTRUCTION=32'h00000013, INSTR_VALID=0, PC_OUT/PC_PLUS4_OUT unchanged.

Decomposition:
- Shared package rv32_pkg:
  - NOP_INSTR constant 32'h00000013
  - fetch state enum {FETCH, HOLD, DISCARD}
  - WIDTH default
- One sub-module, if_id_register: load/hold/bubble controls, reset values as above. The FSM, PC and hold buffer stay in the top module.

Test Plan:
- Zero-wait memory returning addr+0x100, no stall, RESET_PC=0 -> first valid instruction one cycle after the first request; then INSTRUCTION=0x100,0x104,0x108 on consecutive cycles, PC_OUT=0,4,8, PC_PLUS4_OUT=4,8,12.
- BUSYWAIT high 3 cycles per access -> 3 bubbles (INSTRUCTION=0x00000013, INSTR_VALID=0) between valid instructions; IMEM_ADDR constant during each wait.
- STALL asserted 2 cycles while a word completes at PC=8 -> IF/ID holds PC_OUT=4; IMEM_READ=0 during HOLD; after release PC_OUT=8 next, then 12; no instruction lost or duplicated.
- BRANCH_TAKEN with target 0x40 while BUSYWAIT=1 at PC=0x10 -> IMEM_ADDR stays 0x10 until done; that data is discarded; next IMEM_ADDR=0x40; first valid PC_OUT=0x40.
- BRANCH_TAKEN and STALL together in HOLD, target 0x23 -> buffer flushed, bubble, next fetch address 0x20.
- PC=0xFFFFFFFC fetch -> PC_PLUS4_OUT=0, next IMEM_ADDR=0. RESET=0 asserted mid-wait -> next edge INSTR_VALID=0, INSTRUCTION=0x00000013, IMEM_READ=0 while held, restart at RESET_PC.
